// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: accepts bitstream words over valid/ready and shifts them
// LSB-first into one ccff chain. Optional tail CRC-8 is enabled by defining CCFF_TAIL_CRC_EN.
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_left
`ifdef CCFF_TAIL_CRC_EN
    ,
    output logic [7:0]        tail_crc
`endif
);

    localparam int WC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] shreg;
    logic [WC_W-1:0]   wcnt;
    logic              accept, take, last_bit, last_chain_bit;

    always_comb begin
        state_n        = state;
        word_ready     = 1'b0;
        ccff_shift_en  = 1'b0;
        ccff_head      = 1'b0;
        accept         = 1'b0;
        take           = 1'b0;
        last_bit       = (wcnt == WC_W'(WORD_W - 1));
        last_chain_bit = (bits_left <= CNT_W'(1));
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept  = 1'b1;
                    state_n = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                word_ready = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                end else if (word_valid) begin
                    take    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = shreg[0];
                if (abort)
                    state_n = IDLE;
                else if (last_chain_bit)
                    state_n = DONE;
                else if (last_bit)
                    state_n = WAIT_WORD;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The shift still counts on an abort cycle: ccff_shift_en was already high, so the chain moved.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state     <= IDLE;
            shreg     <= '0;
            wcnt      <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                bits_left <= CNT_W'(CHAIN_LEN);
                done      <= 1'b0;
                busy      <= 1'b1;
            end
            if (take) begin
                shreg <= word_data;
                wcnt  <= '0;
            end
            if (state == SHIFT) begin
                shreg <= shreg >> 1;
                wcnt  <= wcnt + 1'b1;
                if (bits_left != '0)
                    bits_left <= bits_left - 1'b1;
            end
            if (state == SHIFT && state_n == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (abort && state != IDLE)
                busy <= 1'b0;
        end
    end

`ifdef CCFF_TAIL_CRC_EN
    // CRC-8, polynomial 0x07, MSB-first over the bits leaving the chain.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset)
            tail_crc <= '0;
        else if (accept)
            tail_crc <= '0;
        else if (ccff_shift_en)
            tail_crc <= {tail_crc[6:0], 1'b0} ^ ({8{tail_crc[7] ^ ccff_tail}} & 8'h07);
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: queue-based model of the expected serial bit
// stream plus directed checks of handshake, abort, reset and completion behaviour.
module tb_ccff_chain_loader;

    localparam int WW = 8;
    localparam int CL = 20;
    localparam int CW = $clog2(CL + 1);

    logic          prog_clk = 1'b0;
    logic          prog_reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] word_data = '0;
    logic          word_valid = 1'b0;
    logic          word_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
    logic [CW-1:0] bits_left;
`ifdef CCFF_TAIL_CRC_EN
    logic [7:0]    tail_crc;
`endif

    ccff_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .bits_left(bits_left)
`ifdef CCFF_TAIL_CRC_EN
        , .tail_crc(tail_crc)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    // Stand-in for the driven chain of mem DFFs.
    logic [CL-1:0] chain = '0;
    always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
    assign ccff_tail = chain[CL-1];

    int n_chk = 0;
    int n_fail = 0;
    bit exp_q[$];
    int exp_left = 0;
    int shift_cnt = 0;
    int assigned = 0;
    logic [CL-1:0] obs_bits = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: enable must track the model queue, head/bits_left must match its next bit.
    always @(negedge prog_clk) begin
        if (!prog_reset) begin
            if (ccff_shift_en) begin
                check("shift_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("head_bit", ccff_head, exp_q.pop_front());
                    check("bits_left_shift", bits_left, exp_left);
                    check("ready_in_shift", word_ready, 0);
                    if (shift_cnt < CL) obs_bits[shift_cnt] = ccff_head;
                    if (exp_left != 0) exp_left--;
                    shift_cnt++;
                end
            end else begin
                check("head_idle", ccff_head, 0);
                check("no_stall", 32'(exp_q.size()), 0);
            end
        end
    end

    task automatic tick();
        @(negedge prog_clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_left = CL; shift_cnt = 0; assigned = 0; obs_bits = '0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_left", bits_left, CL);
        check("start_ready", word_ready, 1);
    endtask

    task automatic send_word(input logic [WW-1:0] data, input int gap);
        int n;
        for (int i = 0; i < 40 && !word_ready; i++) tick();
        check("ready_timeout", word_ready, 1);
        repeat (gap) begin
            check("gap_ready", word_ready, 1);
            check("gap_shift", ccff_shift_en, 0);
            check("gap_left", bits_left, exp_left);
            tick();
        end
        n = (CL - assigned < WW) ? CL - assigned : WW;
        for (int i = 0; i < n; i++) exp_q.push_back(data[i]);
        assigned += n;
        word_valid = 1'b1;
        word_data  = data;
        tick();
        word_valid = 1'b0;
        word_data  = WW'($urandom);
    endtask

    task automatic finish_load();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check("drain_timeout", 32'(exp_q.size()), 0);
        tick();
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_left", bits_left, 0);
        check("end_count", shift_cnt, CL);
        tick();
        check("idle_done", done, 1);
        check("idle_ready", word_ready, 0);
        check("idle_shift", ccff_shift_en, 0);
    endtask

    task automatic random_load(input bit poke_start);
        do_start();
        while (assigned < CL) begin
            send_word(WW'($urandom), $urandom_range(0, 3));
            if (poke_start && assigned < CL && $urandom_range(0, 1) == 1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        finish_load();
    endtask

`ifdef CCFF_TAIL_CRC_EN
    function automatic logic [7:0] crc_of_ones(input int n);
        logic [7:0] c = '0;
        for (int i = 0; i < n; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ 1'b1) ? 8'h07 : 8'h00);
        return c;
    endfunction
`endif

    initial begin
        #1;
        check("rst_ready", word_ready, 0);
        check("rst_shift", ccff_shift_en, 0);
        check("rst_head", ccff_head, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_left", bits_left, 0);
        tick(); tick();
        prog_reset = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);

        // 0xA5, 0x3C, 0xFF: 8+8+4 bits, with a 5-cycle valid gap before the second word.
        do_start();
        send_word(8'hA5, 0);
        send_word(8'h3C, 5);
        send_word(8'hFF, 1);
        finish_load();
        check("pinned_stream", obs_bits, 20'hF3CA5);

        // start together with abort in IDLE is an abort: nothing starts, done survives.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 1);
        check("idle_abort_ready", word_ready, 0);

        // Abort on the second shift cycle of word 1.
        do_start();
        send_word(8'h5A, 0);
        tick();
        abort = 1'b1;
        exp_q.delete();
        tick();
        abort = 1'b0;
        check("abort_shift", ccff_shift_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_left", bits_left, 18);
        tick();
        do_start();

        // Word handshaked in the abort cycle is dropped.
        word_valid = 1'b1; word_data = 8'hFF; abort = 1'b1;
        tick();
        word_valid = 1'b0; abort = 1'b0;
        check("drop_busy", busy, 0);
        check("drop_left", bits_left, CL);
        repeat (4) tick();
        check("drop_shift", ccff_shift_en, 0);

        // start pulses during SHIFT must not disturb the count.
        for (int k = 0; k < 6; k++) random_load(k[0]);

        // Reset mid-SHIFT clears outputs asynchronously.
        do_start();
        send_word(8'hC3, 0);
        tick();
        prog_reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_shift", ccff_shift_en, 0);
        check("mid_rst_head", ccff_head, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_left", bits_left, 0);
        check("mid_rst_ready", word_ready, 0);
        tick();
        prog_reset = 1'b0;
        tick();
        check("post_mid_rst_busy", busy, 0);

`ifdef CCFF_TAIL_CRC_EN
        // Fill the chain with ones, then push zeros: the tail emits CL ones.
        do_start();
        while (assigned < CL) send_word(8'hFF, 0);
        finish_load();
        do_start();
        check("crc_cleared", tail_crc, 0);
        while (assigned < CL) send_word(8'h00, 0);
        finish_load();
        check("tail_crc", tail_crc, crc_of_ones(CL));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
